sort_bitonic_pipe: RTL

- Parametrised, fully pipelined bitonic sorting network.
- Each accepted beat carries NUM_ELEM unsigned keys of DATA_W bits, plus a per-beat direction bit.
- The sorted beat emerges after a fixed number of register stages; throughput is one beat per cycle.
- Sits between the synthetic data generators and downstream consumers; valid/ready handshake on both sides with full backpressure.

---
 rtl/sort_bitonic_pipe.sv | 105 ++++++++++
 1 files changed

// File: rtl/sort_bitonic_pipe.sv
// Fully pipelined bitonic sorting network: one beat of NUM_ELEM unsigned keys per cycle,
// one registered compare-exchange stage per (k, j) pair, global stall from the output side.
module sort_bitonic_pipe #(
   parameter int unsigned NUM_ELEM = 16,
   parameter int unsigned DATA_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_desc,
   input  logic [NUM_ELEM*DATA_W-1:0]   data_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_desc,
   output logic [NUM_ELEM*DATA_W-1:0]   data_out,
   output logic                         busy
);

   localparam int unsigned LOG_N  = $clog2(NUM_ELEM);
   localparam int unsigned STAGES = LOG_N * (LOG_N + 1) / 2;
   localparam int unsigned BUS_W  = NUM_ELEM * DATA_W;

   if (NUM_ELEM < 2 || NUM_ELEM > 64 || (NUM_ELEM & (NUM_ELEM - 1)) != 0) begin : g_bad_num_elem
      $error("sort_bitonic_pipe: NUM_ELEM must be a power of two in 2..64");
   end
   if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
      $error("sort_bitonic_pipe: DATA_W must lie in 1..32");
   end

   logic              stg_valid [STAGES];
   logic              stg_desc  [STAGES];
   logic [BUS_W-1:0]  stg_data  [STAGES];
   logic              stall;

   // Pair (lo, hi) must be exchanged; equal keys never move.
   function automatic logic swap_needed(input logic [DATA_W-1:0] lo,
                                        input logic [DATA_W-1:0] hi,
                                        input logic              up);
      return up ? (lo > hi) : (lo < hi);
   endfunction

   assign stall     = stg_valid[STAGES-1] & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = stg_valid[STAGES-1];
   assign out_desc  = stg_desc[STAGES-1];
   assign data_out  = stg_data[STAGES-1];

   always_comb begin : busy_or
      busy = 1'b0;
      for (int unsigned s = 0; s < STAGES; s++) begin
         busy = busy | stg_valid[s];
      end
   end

   // Stage index S enumerates k = 2^lk (outer) and j = 2^(lj-1) from k/2 down to 1 (inner).
   for (genvar lk = 1; lk <= LOG_N; lk++) begin : g_k
      for (genvar lj = lk; lj >= 1; lj--) begin : g_j
         localparam int unsigned S = lk * (lk - 1) / 2 + (lk - lj);
         localparam int unsigned K = 32'd1 << lk;
         localparam int unsigned J = 32'd1 << (lj - 1);

         logic             src_valid;
         logic             src_desc;
         logic [BUS_W-1:0] src_data;
         logic [BUS_W-1:0] cx_c;

         if (S == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_desc  = in_desc;
            assign src_data  = data_in;
         end else begin : g_body
            assign src_valid = stg_valid[S-1];
            assign src_desc  = stg_desc[S-1];
            assign src_data  = stg_data[S-1];
         end

         always_comb begin : cmp_exch
            cx_c = src_data;
            for (int unsigned i = 0; i < NUM_ELEM; i++) begin
               if (((i ^ J) > i) &&
                   swap_needed(src_data[i*DATA_W +: DATA_W],
                               src_data[(i ^ J)*DATA_W +: DATA_W],
                               ((i & K) == 0) ^ src_desc)) begin
                  cx_c[i*DATA_W +: DATA_W]       = src_data[(i ^ J)*DATA_W +: DATA_W];
                  cx_c[(i ^ J)*DATA_W +: DATA_W] = src_data[i*DATA_W +: DATA_W];
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin : stage_reg
            if (!rst_n) begin
               stg_valid[S] <= 1'b0;
               stg_desc[S]  <= 1'b0;
               stg_data[S]  <= '0;
            end else if (!stall) begin
               stg_valid[S] <= src_valid;
               stg_desc[S]  <= src_desc;
               stg_data[S]  <= cx_c;
            end
         end
      end
   end

endmodule
